// File: rtl/instruction_loader_pkg.sv
// Shared types and defaults for the UART-to-instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          MEM_DEPTH_DEFAULT = 32;

    function automatic logic is_busy(input state_e s);
        return (s == RECV) || (s == WRITE);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Loader bus: UART byte input, start/status and the instruction-memory write port.
interface instruction_loader_if #(
    parameter int ADDR_W = 5
) ();

    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_instruction;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       data_instruction;
    logic              busy;
    logic              load_done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    modport master (
        input  start, rx_data, rx_valid,
        output wr_instruction, wr_addr, data_instruction,
        output busy, load_done, overflow, word_count
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  wr_instruction, wr_addr, data_instruction,
        input  busy, load_done, overflow, word_count
    );

endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Packs four bytes big-endian into a 32-bit word; word_ready flags the completing byte.
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[23:0], byte_in};
        end
    end

    // The shift register is always refilled by four bytes before use, so only the count is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        word_q <= word_d;
    end

    assign word       = word_q;
    assign word_ready = byte_valid && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads UART bytes as 32-bit words into consecutive instruction-memory addresses until halt or full.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int          MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    instruction_loader_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              overflow_q, overflow_d;
    logic              wr_instruction_q, wr_instruction_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       data_instruction_q, data_instruction_d;

    logic [31:0] word;
    logic        word_ready;
    logic        arm;
    logic        is_halt;
    logic        at_last;
    logic        byte_en;

    assign arm     = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign is_halt = (word == HALT_WORD);
    assign at_last = (addr_q == LAST_ADDR);
    // A byte landing in WRITE starts the next word only if loading continues.
    assign byte_en = bus.rx_valid &&
                     ((state_q == RECV) || ((state_q == WRITE) && !is_halt && !at_last));

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (arm),
        .byte_valid (byte_en),
        .byte_in    (bus.rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        word_count_d       = word_count_q;
        overflow_d         = overflow_q;
        wr_instruction_d   = 1'b0;
        wr_addr_d          = wr_addr_q;
        data_instruction_d = data_instruction_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            RECV: begin
                if (word_ready) state_d = WRITE;
            end
            WRITE: begin
                wr_instruction_d   = 1'b1;
                wr_addr_d          = addr_q;
                data_instruction_d = word;
                word_count_d       = word_count_q + 1'b1;
                if (!at_last) addr_d = addr_q + 1'b1;
                if (is_halt) begin
                    state_d    = DONE;
                    overflow_d = 1'b0;
                end else if (at_last) begin
                    state_d    = DONE;
                    overflow_d = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            word_count_q       <= '0;
            overflow_q         <= 1'b0;
            wr_instruction_q   <= 1'b0;
            wr_addr_q          <= '0;
            data_instruction_q <= '0;
        end else begin
            state_q            <= state_d;
            addr_q             <= addr_d;
            word_count_q       <= word_count_d;
            overflow_q         <= overflow_d;
            wr_instruction_q   <= wr_instruction_d;
            wr_addr_q          <= wr_addr_d;
            data_instruction_q <= data_instruction_d;
        end
    end

    assign bus.wr_instruction   = wr_instruction_q;
    assign bus.wr_addr          = wr_addr_q;
    assign bus.data_instruction = data_instruction_q;
    assign bus.busy             = is_busy(state_q);
    assign bus.load_done        = (state_q == DONE);
    assign bus.overflow         = overflow_q;
    assign bus.word_count       = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: writes are logged at the falling edge and checked per scenario.
module tb_instruction_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    instruction_loader_if #(.ADDR_W(5)) bus ();

    instruction_loader #(
        .MEM_DEPTH (32),
        .ADDR_W    (5),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [4:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          n_rise  = 0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (bus.wr_instruction === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.data_instruction);
            if (!prev_wr) n_rise++;
        end
        prev_wr = (bus.wr_instruction === 1'b1);
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 bus.rx_data = b; bus.rx_valid = 1'b1;
        @(posedge clk); #1 bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (bus.load_done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_vec++;
        if (bus.load_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done_timeout: load_done=%b expected 1", nm, bus.load_done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec += 7;
        if (bus.wr_instruction !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b expected 0", bus.wr_instruction); end
        if (bus.wr_addr !== 5'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", bus.wr_addr); end
        if (bus.data_instruction !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h expected 0", bus.data_instruction); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", bus.load_done); end
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow); end
        if (bus.word_count !== 6'd0) begin n_err++; $display("FAIL rst_wc: got %0d expected 0", bus.word_count); end
    endtask

    task automatic test_reset_mid_load();
        int base;
        do_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_rst();
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        base = wq_addr.size();
        do_start();
        send_word(32'h0022_1820);
        idle_cycles(3);
        n_vec += 4;
        if (wq_addr.size() - base !== 1) begin n_err++; $display("FAIL midrst_nwr: got %0d expected 1", wq_addr.size() - base); end
        if (wq_addr.size() > base && wq_addr[base] !== 5'd0) begin n_err++; $display("FAIL midrst_addr: got %0d expected 0", wq_addr[base]); end
        if (wq_data.size() <= base || wq_data[base] !== 32'h0022_1820) begin n_err++; $display("FAIL midrst_data: got %h expected 00221820", bus.data_instruction); end
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy2: got %b expected 1", bus.busy); end
    endtask

    task automatic test_normal_load();
        int base;
        pulse_rst();
        base = wq_addr.size();
        do_start();
        send_word(32'h0022_1820);
        send_word(32'hFFFF_FFFF);
        wait_done("normal");
        n_vec += 9;
        if (wq_addr.size() - base !== 2) begin n_err++; $display("FAIL normal_nwr: got %0d expected 2", wq_addr.size() - base); end
        if (wq_addr.size() > base + 1) begin
            if (wq_addr[base] !== 5'd0 || wq_data[base] !== 32'h0022_1820) begin n_err++; $display("FAIL normal_w1: got %0d/%h expected 0/00221820", wq_addr[base], wq_data[base]); end
            if (wq_addr[base+1] !== 5'd1 || wq_data[base+1] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL normal_w2: got %0d/%h expected 1/ffffffff", wq_addr[base+1], wq_data[base+1]); end
        end else begin
            n_err += 2; $display("FAIL normal_words: got %0d writes expected 2", wq_addr.size() - base);
        end
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL normal_ovf: got %b expected 0", bus.overflow); end
        if (bus.word_count !== 6'd2) begin n_err++; $display("FAIL normal_wc: got %0d expected 2", bus.word_count); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL normal_busy: got %b expected 0", bus.busy); end
        if (bus.wr_addr !== 5'd1) begin n_err++; $display("FAIL normal_hold_addr: got %0d expected 1", bus.wr_addr); end
        if (bus.data_instruction !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL normal_hold_data: got %h expected ffffffff", bus.data_instruction); end
        if (bus.wr_instruction !== 1'b0) begin n_err++; $display("FAIL normal_strobe_low: got %b expected 0", bus.wr_instruction); end
    endtask

    task automatic test_ignored_inputs();
        int base;
        pulse_rst();
        base = wq_addr.size();
        send_word(32'hCAFE_F00D);
        idle_cycles(3);
        n_vec += 2;
        if (wq_addr.size() - base !== 0) begin n_err++; $display("FAIL idle_bytes_nwr: got %0d expected 0", wq_addr.size() - base); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_bytes_busy: got %b expected 0", bus.busy); end
        do_start();
        send_byte(8'h12);
        send_byte(8'h34);
        do_start();
        send_byte(8'h56);
        send_byte(8'h78);
        idle_cycles(3);
        n_vec += 4;
        if (wq_addr.size() - base !== 1) begin n_err++; $display("FAIL start_in_recv_nwr: got %0d expected 1", wq_addr.size() - base); end
        if (wq_data.size() <= base || wq_data[base] !== 32'h1234_5678 || wq_addr[base] !== 5'd0) begin n_err++; $display("FAIL start_in_recv_word: got %h expected 12345678 at 0", bus.data_instruction); end
        if (bus.word_count !== 6'd1) begin n_err++; $display("FAIL start_in_recv_wc: got %0d expected 1", bus.word_count); end
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL start_in_recv_busy: got %b expected 1", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int base;
        int rise0;
        pulse_rst();
        do_start();
        base  = wq_addr.size();
        rise0 = n_rise;
        @(posedge clk); #1 bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 8'(i + 1);
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        idle_cycles(3);
        n_vec += 5;
        if (wq_addr.size() - base !== 2) begin n_err++; $display("FAIL b2b_nwr: got %0d expected 2", wq_addr.size() - base); end
        if (n_rise - rise0 !== 2) begin n_err++; $display("FAIL b2b_strobes: got %0d expected 2", n_rise - rise0); end
        if (wq_data.size() <= base || wq_data[base] !== 32'h0102_0304 || wq_addr[base] !== 5'd0) begin n_err++; $display("FAIL b2b_w1: expected 01020304 at 0, log size %0d", wq_data.size() - base); end
        if (wq_data.size() <= base + 1 || wq_data[base+1] !== 32'h0506_0708 || wq_addr[base+1] !== 5'd1) begin n_err++; $display("FAIL b2b_w2: expected 05060708 at 1, log size %0d", wq_data.size() - base); end
        if (bus.word_count !== 6'd2) begin n_err++; $display("FAIL b2b_wc: got %0d expected 2", bus.word_count); end
    endtask

    task automatic test_full_memory();
        int base;
        int rise0;
        logic [31:0] w;
        pulse_rst();
        do_start();
        base  = wq_addr.size();
        rise0 = n_rise;
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'hA5, 8'h5A, ~8'(i)};
            send_word(w);
        end
        wait_done("full");
        n_vec += 5;
        if (wq_addr.size() - base !== 32) begin n_err++; $display("FAIL full_nwr: got %0d expected 32", wq_addr.size() - base); end
        if (n_rise - rise0 !== wq_addr.size() - base) begin n_err++; $display("FAIL full_strobe_width: got %0d strobe cycles for %0d strobes", wq_addr.size() - base, n_rise - rise0); end
        if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %b expected 1", bus.overflow); end
        if (bus.word_count !== 6'd32) begin n_err++; $display("FAIL full_wc: got %0d expected 32", bus.word_count); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL full_busy: got %b expected 0", bus.busy); end
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'hA5, 8'h5A, ~8'(i)};
            n_vec++;
            if (wq_addr.size() <= base + i || wq_addr[base+i] !== 5'(i) || wq_data[base+i] !== w) begin
                n_err++;
                $display("FAIL full_word%0d: expected %h at %0d, log size %0d", i, w, i, wq_addr.size() - base);
            end
        end
        send_word(32'h1357_9BDF);
        idle_cycles(3);
        n_vec += 3;
        if (wq_addr.size() - base !== 32) begin n_err++; $display("FAIL full_extra_nwr: got %0d expected 32", wq_addr.size() - base); end
        if (bus.wr_addr !== 5'd31) begin n_err++; $display("FAIL full_extra_addr: got %0d expected 31", bus.wr_addr); end
        if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL full_extra_done: got %b expected 1", bus.load_done); end
    endtask

    task automatic test_strobe_and_rearm();
        do_start();
        @(negedge clk);
        n_vec += 4;
        if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL rearm_done: got %b expected 0", bus.load_done); end
        if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rearm_ovf: got %b expected 0", bus.overflow); end
        if (bus.word_count !== 6'd0) begin n_err++; $display("FAIL rearm_wc: got %0d expected 0", bus.word_count); end
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rearm_busy: got %b expected 1", bus.busy); end
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        @(posedge clk); #1 bus.rx_data = 8'hEF; bus.rx_valid = 1'b1;
        @(posedge clk); #1 bus.rx_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.wr_instruction !== 1'b0) begin n_err++; $display("FAIL strobe_early: got %b expected 0", bus.wr_instruction); end
        @(negedge clk);
        n_vec += 3;
        if (bus.wr_instruction !== 1'b1) begin n_err++; $display("FAIL strobe_on: got %b expected 1", bus.wr_instruction); end
        if (bus.wr_addr !== 5'd0) begin n_err++; $display("FAIL rearm_addr: got %0d expected 0", bus.wr_addr); end
        if (bus.data_instruction !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rearm_data: got %h expected deadbeef", bus.data_instruction); end
        @(negedge clk);
        n_vec += 2;
        if (bus.wr_instruction !== 1'b0) begin n_err++; $display("FAIL strobe_off: got %b expected 0", bus.wr_instruction); end
        if (bus.data_instruction !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL strobe_hold_data: got %h expected deadbeef", bus.data_instruction); end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_reset_mid_load();
        test_normal_load();
        test_ignored_inputs();
        test_back_to_back();
        test_full_memory();
        test_strobe_and_rearm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Debug-side loader directly upstream of the instruction memory. It assembles UART receive bytes into 32-bit MIPS instruction words and writes them into consecutive instruction-memory addresses using the memory's `wr_instruction` / `data_instruction` write port. Loading stops on a halt word or when the memory is full. It then reports completion so the debug unit can release the processor from reset.

## Interface
Parameters:
- `MEM_DEPTH`, 32: instruction-memory depth in words.
- `ADDR_W`, 5: write-address width; equals log2(`MEM_DEPTH`).
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms a new load.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `wr_instruction`  out  1  instruction-memory write strobe.
- `wr_addr`  out  ADDR_W  instruction-memory word address.
- `data_instruction`  out  32  word to write.
- `busy`  out  1  high while in RECV or WRITE.
- `load_done`  out  1  high in DONE, held until the next `start` or `rst`.
- `overflow`  out  1  memory filled before a halt word arrived; valid while `load_done` is high.
- `word_count`  out  ADDR_W+1  number of words written, halt word included.

## Operation
States are IDLE, RECV, WRITE and DONE.
- **IDLE:** `rx_valid` is ignored. On `start`, go to RECV and clear the byte counter, address, `word_count`, `overflow` and `load_done`.
- **RECV:** on each `rx_valid`, shift `word <= {word[23:0], rx_data}`, so the first byte is the MSB (big-endian). Increment the 2-bit byte counter. On the 4th byte, go to WRITE and wrap the byte counter to 0.
- **WRITE** (exactly 1 cycle):
  - Drive `wr_instruction=1`, `data_instruction=word`, `wr_addr=addr`.
  - Then `addr++` and `word_count++`.
  - Next state:
    - Word == `HALT_WORD`: DONE, `overflow=0`. The halt word itself is written.
    - Else if `addr == MEM_DEPTH-1`: DONE, `overflow=1`.
    - Else: RECV.
  - An `rx_valid` arriving in WRITE is captured as byte 0 of the next word when the next state is RECV. It is discarded when the next state is DONE.
- **DONE:** `load_done=1`, `busy=0`. Bytes are ignored. `start` re-arms with the same clearing as from IDLE.
- `start` is ignored in RECV and WRITE.
- `wr_addr` never exceeds `MEM_DEPTH-1`; the address never wraps.

## Timing
- Reset values: state IDLE; `wr_instruction=0`, `wr_addr=0`, `data_instruction=0`, `busy=0`, `load_done=0`, `overflow=0`, `word_count=0`.
- `rst` asserted mid-load aborts immediately on the next edge. A write pending in that cycle is not issued.
- `wr_instruction` is registered and rises on the edge after the edge that sampled the 4th `rx_valid` (1-cycle latency). It stays high for exactly one full clock cycle.
- `wr_addr` and `data_instruction` are registered and stable during and outside the strobe cycle. `data_instruction` holds the last written word until the next write.
- `load_done` rises on the edge after the final write cycle.
- `busy` rises on the edge after `start` is sampled and falls when `load_done` rises.
- Upper bound for the UART rate: at least 1 idle cycle between `rx_valid` pulses. Back-to-back pulses are still accepted in RECV.

## Structure
- Package `loader_pkg`: state enum (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3), `HALT_WORD`, default `MEM_DEPTH`.
- Sub-module `byte_assembler`:
  - Contents: 32-bit shift register, 2-bit byte counter, clear input.
  - Outputs: `word` and a one-cycle `word_ready` pulse.
  - The top level holds the FSM, address counter and output registers.

## Test plan
- **Reset mid-load:** `rst` during RECV after 2 bytes, then `start` + bytes 8'h00,8'h22,8'h18,8'h20 → the write is 32'h00221820 at address 0; the stale partial bytes are not used.
- **Normal load:** `start`, then 8 bytes 00 22 18 20 FF FF FF FF →
  - Write 1: 32'h00221820 at address 0.
  - Write 2: 32'hFFFFFFFF at address 1.
  - Then `load_done=1`, `overflow=0`, `word_count=2`, `busy=0`.
- **Full memory:** 32 non-halt words → 32 writes at addresses 0..31, then `load_done=1`, `overflow=1`, `word_count=32`. A 33rd word's bytes are ignored and produce no write.
- **Ignored inputs:**
  - Bytes in IDLE produce no writes.
  - A `start` in RECV does not reset the byte counter: the 4 bytes spanning it still form one word.
- **Strobe timing and re-arm:**
  - `wr_instruction` is high for exactly 1 cycle, the cycle after the 4th `rx_valid`.
  - After DONE, `start` clears `load_done`, `overflow` and `word_count`, and the next write goes to address 0.
